rx_window_controller: RTL

//  Sequences one tag-reply receive window around the preamble detector.

---
 rtl/rx_window_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rx_window_controller.sv
`default_nettype none
// ============================================================================
// Module   : rx_window_controller
// Purpose  : Sequences one tag-reply receive window (guard, listen, receive)
//            around the preamble detector and reports the closing status.
// Revision : 1.0 - initial release
// ============================================================================
module rx_window_controller #(
    parameter  int BANKS         = 4,
    parameter  int CNT_WIDTH     = 10,
    parameter  int TMR_WIDTH     = 16,
    parameter  int GUARD_CYCLES  = 200,
    parameter  int LISTEN_CYCLES = 4000,
    parameter  int BIT_TIMEOUT   = 1000,
    localparam int BANK_WIDTH    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [CNT_WIDTH-1:0]  expected_bits,
    input  logic                  abort,
    input  logic                  tx_busy,
    input  logic                  smp_vld_in,
    output logic                  smp_vld_out,
    output logic                  det_rst,
    input  logic                  preamble_detected,
    input  logic                  postamble_detected,
    input  logic [BANK_WIDTH-1:0] frequency_bank,
    input  logic                  bit_vld,
    output logic                  rx_busy,
    output logic                  rx_done,
    output logic [1:0]            rx_status,
    output logic [BANK_WIDTH-1:0] rx_bank,
    output logic [CNT_WIDTH-1:0]  rx_bit_count
);

    localparam logic [TMR_WIDTH-1:0] c_guard_last  = TMR_WIDTH'(GUARD_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] c_listen_last = TMR_WIDTH'(LISTEN_CYCLES - 1);
    localparam logic [TMR_WIDTH-1:0] c_bit_last    = TMR_WIDTH'(BIT_TIMEOUT - 1);

    localparam logic [1:0] c_st_ok    = 2'b00;
    localparam logic [1:0] c_st_nopre = 2'b01;
    localparam logic [1:0] c_st_short = 2'b10;
    localparam logic [1:0] c_st_stall = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GUARD   = 3'd1,
        ST_LISTEN  = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic [TMR_WIDTH-1:0]  r_timer;
    logic [CNT_WIDTH-1:0]  r_exp_bits;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_final_bit;

    // Bit counter saturates so an unbounded reply can never wrap to a false match.
    assign w_cnt_inc   = (&rx_bit_count) ? rx_bit_count : rx_bit_count + 1'b1;
    assign w_final_bit = bit_vld && (r_exp_bits != '0) && (w_cnt_inc == r_exp_bits);

    assign smp_vld_out = smp_vld_in && ((r_state == ST_LISTEN) || (r_state == ST_RECEIVE));
    assign rx_busy     = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_exp_bits   <= '0;
            det_rst      <= 1'b1;
            rx_done      <= 1'b0;
            rx_status    <= c_st_ok;
            rx_bank      <= '0;
            rx_bit_count <= '0;
        end else begin
            rx_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                det_rst <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (arm) begin
                            r_state      <= ST_GUARD;
                            r_exp_bits   <= expected_bits;
                            r_timer      <= '0;
                            rx_bit_count <= '0;
                            rx_bank      <= '0;
                            rx_status    <= c_st_ok;
                        end
                    end
                    ST_GUARD: begin
                        if (tx_busy) begin
                            r_timer <= '0;
                        end else if (r_timer == c_guard_last) begin
                            r_state <= ST_LISTEN;
                            r_timer <= '0;
                            det_rst <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_LISTEN: begin
                        if (preamble_detected) begin
                            r_state <= ST_RECEIVE;
                            rx_bank <= frequency_bank;
                            r_timer <= '0;
                        end else if (r_timer == c_listen_last) begin
                            r_state   <= ST_DONE;
                            r_timer   <= '0;
                            rx_status <= c_st_nopre;
                            rx_done   <= 1'b1;
                            det_rst   <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_RECEIVE: begin
                        if (bit_vld) begin
                            rx_bit_count <= w_cnt_inc;
                            r_timer      <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                        // A final bit outranks a coincident postamble, so that case reports OK.
                        if (w_final_bit || postamble_detected) begin
                            r_state   <= ST_DONE;
                            r_timer   <= '0;
                            rx_status <= (w_final_bit || (r_exp_bits == '0)) ? c_st_ok : c_st_short;
                            rx_done   <= 1'b1;
                            det_rst   <= 1'b1;
                        end else if (!bit_vld && (r_timer == c_bit_last)) begin
                            r_state   <= ST_DONE;
                            r_timer   <= '0;
                            rx_status <= c_st_stall;
                            rx_done   <= 1'b1;
                            det_rst   <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        det_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
